// File: rtl/seq_count_rr_arb_up_dn.sv
// Round-robin arbiter sharing one registered up/down counter among NREQ requesters.
// Define SEQ_COUNT_RR_ARB_SAT_EN to saturate at 0 and 2^WIDTH-1 instead of wrapping.
module seq_count_rr_arb_up_dn #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 3,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_val,
    input  logic [NREQ-1:0]  req_op,
    output logic [NREQ-1:0]  req_rdy,
    output logic             grant_val,
    output logic [IDW-1:0]   grant_id,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW:0]     arb_sum;
    logic [IDW-1:0]   arb_idx;
    logic             gnt_op;

    // Search from ptr upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        arb_sum   = '0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (arb_sum >= (IDW+1)'(NREQ)) begin
                arb_sum = arb_sum - (IDW+1)'(NREQ);
            end
            arb_idx = IDW'(arb_sum);
            if (!gnt_found && req_val[arb_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = arb_idx;
            end
        end
        if (reset) begin
            gnt_found = 1'b0;
            gnt_idx   = '0;
        end
    end

    assign gnt_op    = req_op[gnt_idx];
    assign grant_val = gnt_found;
    assign grant_id  = gnt_idx;
    assign req_rdy   = gnt_found ? (NREQ'(1) << gnt_idx) : '0;
    assign out       = counter_q;

    // Apply the single accepted command and rotate priority past the winner.
    always_comb begin
        counter_d = counter_q;
        ptr_d     = ptr_q;
        if (gnt_found) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`ifdef SEQ_COUNT_RR_ARB_SAT_EN
            if (!gnt_op && (counter_q != '1)) begin
                counter_d = counter_q + WIDTH'(1);
            end else if (gnt_op && (counter_q != '0)) begin
                counter_d = counter_q - WIDTH'(1);
            end
`else
            if (!gnt_op) begin
                counter_d = counter_q + WIDTH'(1);
            end else begin
                counter_d = counter_q - WIDTH'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= '0;
            ptr_q     <= '0;
        end else begin
            counter_q <= counter_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_seq_count_rr_arb_up_dn.sv
// Self-checking bench for seq_count_rr_arb_up_dn: directed steps then random traffic
// against an arithmetic reference model (honours SEQ_COUNT_RR_ARB_SAT_EN).
module tb_seq_count_rr_arb_up_dn;

    localparam int NREQ  = 4;
    localparam int WIDTH = 3;
    localparam int IDW   = 2;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req_val;
    logic [NREQ-1:0]  req_op;
    logic [NREQ-1:0]  req_rdy;
    logic             grant_val;
    logic [IDW-1:0]   grant_id;
    logic [WIDTH-1:0] out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_cnt = 0;
    int m_ptr = 0;
    int last_g = -1;

    seq_count_rr_arb_up_dn #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_op    (req_op),
        .req_rdy   (req_rdy),
        .grant_val (grant_val),
        .grant_id  (grant_id),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_arb(input logic r, input logic [NREQ-1:0] v);
        if (r) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check arbitration, clock, check counter.
    task automatic step(input string tag, input logic r, input logic [NREQ-1:0] v,
                        input logic [NREQ-1:0] op);
        int g;
        int e_rdy;
        reset   = r;
        req_val = v;
        req_op  = op;
        #1;
        g = model_arb(r, v);
        e_rdy = (g < 0) ? 0 : (1 << g);
        chk({tag, ".rdy"}, 32'(req_rdy), 32'(e_rdy));
        chk({tag, ".gval"}, 32'(grant_val), 32'(g >= 0));
        chk({tag, ".gid"}, 32'(grant_id), 32'((g < 0) ? 0 : g));
        @(posedge clk);
        if (r) begin
            m_cnt = 0;
            m_ptr = 0;
        end else if (g >= 0) begin
`ifdef SEQ_COUNT_RR_ARB_SAT_EN
            if (!op[g]) m_cnt = (m_cnt == MAXV) ? MAXV : m_cnt + 1;
            else        m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
`else
            if (!op[g]) m_cnt = (m_cnt + 1) % (MAXV + 1);
            else        m_cnt = (m_cnt + MAXV) % (MAXV + 1);
`endif
            m_ptr = (g + 1) % NREQ;
        end
        last_g = g;
        #1;
        chk({tag, ".out"}, 32'(out), 32'(m_cnt));
    endtask

    logic [NREQ-1:0] pend_v;
    logic [NREQ-1:0] pend_op;

    initial begin
        reset = 1'b1;
        req_val = '0;
        req_op  = '0;
        #1;

        // Reset with requests present, then idle
        step("rst0", 1'b1, 4'b1111, 4'b0000);
        step("rst1", 1'b1, 4'b1111, 4'b1111);
        chk("rst.out0", 32'(out), 32'd0);
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 4'b0000, 4'b0000);

        // Up-count through wrap
        for (int i = 0; i < 9; i++) begin
            step("wrapup", 1'b0, 4'b0001, 4'b0000);
`ifndef SEQ_COUNT_RR_ARB_SAT_EN
            chk("wrapup.seq", 32'(out), 32'((i + 1) % 8));
`endif
        end

        // Down-count through wrap from 0 with requester 2
        step("rst2", 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            step("wrapdn", 1'b0, 4'b0100, 4'b0100);
            chk("wrapdn.id", 32'(last_g), 32'd2);
`ifndef SEQ_COUNT_RR_ARB_SAT_EN
            chk("wrapdn.seq", 32'(out), 32'(7 - i));
`endif
        end

        // Strict rotation with all requesters valid
        step("rst3", 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step("rr", 1'b0, 4'b1111, 4'b0000);
            chk("rr.order", 32'(last_g), 32'(i % NREQ));
        end

        // Skip idle requesters with mixed ops, starting from ptr=2
        step("rst4", 1'b1, 4'b0000, 4'b0000);
        step("g1", 1'b0, 4'b0010, 4'b0000);
        step("mix0", 1'b0, 4'b1001, 4'b1000);
        chk("mix0.id", 32'(last_g), 32'd3);
        step("mix1", 1'b0, 4'b1001, 4'b1000);
        chk("mix1.id", 32'(last_g), 32'd0);
        step("mix2", 1'b0, 4'b1001, 4'b1000);
        chk("mix2.id", 32'(last_g), 32'd3);

        // Boundary at max and at zero using requester 1
        step("rst5", 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < MAXV; i++) step("tomax", 1'b0, 4'b0010, 4'b0000);
        chk("atmax", 32'(out), 32'(MAXV));
        step("overmax", 1'b0, 4'b0010, 4'b0000);
        step("rst6", 1'b1, 4'b0000, 4'b0000);
        step("underzero", 1'b0, 4'b0010, 4'b0010);

        // Reset in the middle of a burst, then re-arbitrate from ptr=0
        step("burst0", 1'b0, 4'b1111, 4'b0101);
        step("burst1", 1'b0, 4'b1111, 4'b0101);
        step("midrst", 1'b1, 4'b1111, 4'b0101);
        chk("midrst.out", 32'(out), 32'd0);
        step("postrst", 1'b0, 4'b1111, 4'b0101);
        chk("postrst.id", 32'(last_g), 32'd0);

        // Random requesters that hold op until accepted
        pend_v  = '0;
        pend_op = '0;
        for (int c = 0; c < 400; c++) begin
            logic r;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && ($urandom_range(0, 2) == 0)) begin
                    pend_v[i]  = 1'b1;
                    pend_op[i] = 1'($urandom_range(0, 1));
                end
            end
            r = ($urandom_range(0, 49) == 0);
            step("rand", r, pend_v, pend_op);
            if (last_g >= 0) pend_v[last_g] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
